// File: rtl/csr_write_unit_if.sv
// CSR access bus between the pipeline and the machine-mode CSR write unit.
// The pipeline drives the access/trap/interrupt inputs; the unit returns read data and the CSR state.
`timescale 1ns/1ps
interface csr_write_unit_if #(parameter int XLEN = 32);
    logic            i_csr_en;
    logic [2:0]      i_csr_op;
    logic [11:0]     i_csr_addr;
    logic [4:0]      i_rs1_addr;
    logic [XLEN-1:0] i_rs1_data;
    logic            i_trap;
    logic [XLEN-1:0] i_trap_cause;
    logic [XLEN-1:0] i_trap_pc;
    logic            i_mret;
    logic            i_mextern_intr;
    logic            i_mtimer_intr;
    logic            i_msoftware_intr;
    logic [XLEN-1:0] o_csr_rdata;
    logic            o_illegal;
    logic            o_mintr_en;
    logic            o_mpie;
    logic [1:0]      o_mpp;
    logic            o_mextern_intr_en;
    logic            o_mtimer_intr_en;
    logic            o_msoftware_intr_en;
    logic [XLEN-1:0] o_mscratch;
    logic [XLEN-1:0] o_mepc;
    logic [XLEN-1:0] o_mcause;
    logic [63:0]     o_mcycle;

    modport master (
        output i_csr_en, i_csr_op, i_csr_addr, i_rs1_addr, i_rs1_data,
               i_trap, i_trap_cause, i_trap_pc, i_mret,
               i_mextern_intr, i_mtimer_intr, i_msoftware_intr,
        input  o_csr_rdata, o_illegal, o_mintr_en, o_mpie, o_mpp,
               o_mextern_intr_en, o_mtimer_intr_en, o_msoftware_intr_en,
               o_mscratch, o_mepc, o_mcause, o_mcycle
    );

    modport slave (
        input  i_csr_en, i_csr_op, i_csr_addr, i_rs1_addr, i_rs1_data,
               i_trap, i_trap_cause, i_trap_pc, i_mret,
               i_mextern_intr, i_mtimer_intr, i_msoftware_intr,
        output o_csr_rdata, o_illegal, o_mintr_en, o_mpie, o_mpp,
               o_mextern_intr_en, o_mtimer_intr_en, o_msoftware_intr_en,
               o_mscratch, o_mepc, o_mcause, o_mcycle
    );
endinterface

// File: rtl/csr_write_unit.sv
// Machine-mode CSR file: read-modify-write access, trap/mret side effects on mstatus/mepc/mcause,
// and a free-running 64-bit mcycle counter. Reads are combinational, writes land on the next edge.
`timescale 1ns/1ps
module csr_write_unit #(
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MTVEC_VAL = 32'h0000_0100
) (
    input logic             i_clk,
    input logic             i_rst_n,
    csr_write_unit_if.slave csr
);
    localparam int XLEN = 32;

    logic            mie_q, mpie_q;
    logic            meie_q, mtie_q, msie_q;
    logic [XLEN-1:0] mscratch_q, mepc_q, mcause_q;
    logic [63:0]     mcycle_q;

    logic            known;
    logic [XLEN-1:0] old_val, src, wdata;
    logic            wr_suppress, illegal, wr_en;

    always_comb begin
        old_val = '0;
        known   = 1'b1;
        case (csr.i_csr_addr)
            12'h300: old_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h301: old_val = 32'h4000_0100;
            12'h304: old_val = {20'b0, meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0};
            12'h305: old_val = MTVEC_VAL;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h344: old_val = {20'b0, csr.i_mextern_intr, 3'b0, csr.i_mtimer_intr,
                                3'b0, csr.i_msoftware_intr, 3'b0};
            12'hB00: old_val = mcycle_q[31:0];
            12'hB80: old_val = mcycle_q[63:32];
            12'hF11, 12'hF12, 12'hF13: old_val = '0;
            12'hF14: old_val = HART_ID;
            default: known = 1'b0;
        endcase
    end

    // Set/clear with a zero source (x0 or zimm 0) is a pure read, which is what
    // makes it legal against the read-only 0xCxx/0xFxx space.
    always_comb begin
        src         = csr.i_csr_op[2] ? {{(XLEN-5){1'b0}}, csr.i_rs1_addr} : csr.i_rs1_data;
        wr_suppress = (csr.i_csr_op[1:0] != 2'b01) && (csr.i_rs1_addr == 5'd0);
        illegal     = csr.i_csr_en && (!known || (csr.i_csr_op[1:0] == 2'b00) ||
                      ((csr.i_csr_addr[11:10] == 2'b11) && !wr_suppress));
        wr_en       = csr.i_csr_en && !illegal && !wr_suppress;
        case (csr.i_csr_op[1:0])
            2'b10:   wdata = old_val | src;
            2'b11:   wdata = old_val & ~src;
            default: wdata = src;
        endcase
    end

    // Trap beats mret beats a CSR write, but only on the fields the winner touches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (csr.i_trap) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (csr.i_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en && (csr.i_csr_addr == 12'h300)) begin
            mie_q  <= wdata[3];
            mpie_q <= wdata[7];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (csr.i_trap) begin
            mepc_q   <= {csr.i_trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= csr.i_trap_cause;
        end else if (wr_en && (csr.i_csr_addr == 12'h341)) begin
            mepc_q   <= {wdata[XLEN-1:2], 2'b00};
        end else if (wr_en && (csr.i_csr_addr == 12'h342)) begin
            mcause_q <= wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            msie_q     <= 1'b0;
            mscratch_q <= '0;
        end else if (wr_en && (csr.i_csr_addr == 12'h304)) begin
            meie_q <= wdata[11];
            mtie_q <= wdata[7];
            msie_q <= wdata[3];
        end else if (wr_en && (csr.i_csr_addr == 12'h340)) begin
            mscratch_q <= wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            mcycle_q <= '0;
        else if (wr_en && (csr.i_csr_addr == 12'hB00))
            mcycle_q <= {mcycle_q[63:32], wdata};
        else if (wr_en && (csr.i_csr_addr == 12'hB80))
            mcycle_q <= {wdata, mcycle_q[31:0]};
        else
            mcycle_q <= mcycle_q + 64'd1;
    end

    assign csr.o_csr_rdata         = old_val;
    assign csr.o_illegal           = illegal;
    assign csr.o_mintr_en          = mie_q;
    assign csr.o_mpie              = mpie_q;
    assign csr.o_mpp               = 2'b11;
    assign csr.o_mextern_intr_en   = meie_q;
    assign csr.o_mtimer_intr_en    = mtie_q;
    assign csr.o_msoftware_intr_en = msie_q;
    assign csr.o_mscratch          = mscratch_q;
    assign csr.o_mepc              = mepc_q;
    assign csr.o_mcause            = mcause_q;
    assign csr.o_mcycle            = mcycle_q;
endmodule
